xin8_hs: RTL
============

Name: xin8_hs

Overview:
- Handshaked 8-bit parallel input port peripheral on the XSOC abstract control bus.
- Receiving end of an external strobed byte link (Centronics-style): the external writer drives i[7:0] and pulses stb_n.
- The block latches the byte, raises busy until the CPU reads it, then returns an ack_n pulse.
- CPU access uses the same sel/ctrl/d scheme as the other simple I/O peripherals: data register at addr[0]=0, status register at addr[0]=1.

Parameters:
- ACK_CYC, 4, width of the ack_n low pulse in clk cycles (1..15).
- SYNC_STAGES, 2, flops in the stb_n synchronizer (>=2).

Ports:
- clk  input  1  global clock
- rst  input  1  global reset, synchronous, active-low
- ctrl  input  16  abstract control bus
- sel  input  1  peripheral select
- d  inout  8  LSB byte of on-chip data bus; driven only during reads of this peripheral, otherwise high-Z
- i  input  8  external data pads
- stb_n  input  1  external strobe, asynchronous, active-low
- ack_n  output  1  acknowledge pad, active-low pulse
- busy  output  1  busy pad, high while a byte is held unread

Behaviour:
- Reset (rst==0 at posedge clk): data_q=0, full=0, ovr=0, sync chain=all 1, ack state IDLE, ack_n=1, busy=0. d is high-Z.
- The decoder's own reset input is driven with ~rst.
- Decode comes from ctrl_dec: rd = sel & ~ld_t; wr = ld_ce.
- Strobe path:
  - stb_n passes through SYNC_STAGES flops, then one more delay flop.
  - fall = sync_out==0 & delay==1.
  - A stb_n low of at least SYNC_STAGES+1 cycles is guaranteed to be seen exactly once.
- Capture:
  - On fall with full==0 and no data read in the same cycle: data_q<=i and full<=1.
  - Latency: full rises at posedge SYNC_STAGES+1 after stb_n low setup.
  - The external writer holds i stable while stb_n is low.
- Overrun: fall while full==1 sets ovr<=1. data_q is unchanged and the new byte is dropped.
- Simultaneous fall and data read: treated as overrun-free capture is lost.
  - Full clears, ovr sets, data_q unchanged.
  - Rationale: the read wins and the writer must retry after ack_n.
- Data read (rd & addr[0]==0):
  - d = data_q, combinational while rd.
  - First read cycle (rd rising, tracked with a registered rd_prev) clears full and starts ack.
  - Multi-cycle reads clear only once.
- Status read (rd & addr[0]==1): d = {5'b0, sync_out inverted (stb active), ovr, full}. No side effects.
- Status write (wr & addr[0]==1): d[1]==1 clears ovr. Writes to addr[0]==0 are ignored.
- busy = full, registered, so there are no glitches on the pad.
- Ack FSM, states IDLE and ACK, with a 4-bit counter:
  - IDLE -> ACK on the data-read clear event; cnt <= ACK_CYC-1; ack_n <= 0.
  - In ACK, cnt decrements each cycle; at cnt==0 go to IDLE with ack_n <= 1.
  - ack_n is low for exactly ACK_CYC cycles.
  - A second clear event during ACK reloads cnt, extending the pulse.
  - A capture during ACK is allowed.
- Reset mid-operation: everything returns to reset values next edge. ack_n goes high immediately at that edge, and any pending byte is discarded.

Decomposition:
- Shared package (xsoc_io_pkg):
  - register offsets: REG_DATA=0, REG_STAT=1;
  - status bit indices: ST_FULL=0, ST_OVR=1, ST_STB=2;
  - ack FSM state encoding.
- Reuse the existing ctrl_dec for bus decode; no new decode logic.
- One natural sub-module, sync_fall (parameterized synchronizer plus falling-edge detect). It is reusable by future strobed inputs.

Test Plan:
- Reset → ack_n=1, busy=0, status read returns 8'h04 only if stb_n low, else 8'h00; d high-Z when sel=0.
- stb_n low 4 cycles with i=8'hA5 → busy=1 at posedge 3, status=8'h01; data read returns 8'hA5; busy=0 next edge; ack_n low exactly 4 cycles.
- Second strobe (i=8'h3C) before the read → ovr=1, status=8'h03; data read still returns 8'hA5; status write d=8'h02 → status=8'h00.
- Strobe falling edge in the same cycle as a data read → full=0, ovr=1, data_q unchanged.
- 3-cycle data read → only one ack pulse of ACK_CYC cycles; new strobe during the ack pulse captures correctly, busy=1 while ack_n still low.
- rst asserted during the ack pulse with full=1 → next edge ack_n=1, busy=0, status=8'h00, d high-Z.

Source files
------------

// File: rtl/xsoc_io_pkg.sv
// Shared definitions for the simple XSOC I/O peripherals: register map,
// status bit layout, control bus field positions and the ack FSM encoding.
package xsoc_io_pkg;

    localparam logic REG_DATA = 1'b0;
    localparam logic REG_STAT = 1'b1;

    localparam int ST_FULL = 0;
    localparam int ST_OVR  = 1;
    localparam int ST_STB  = 2;

    // Field positions inside the 16-bit abstract control bus.
    localparam int CTRL_RD   = 0;
    localparam int CTRL_WR   = 1;
    localparam int CTRL_ADDR = 2;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } ack_state_t;

endpackage

// File: rtl/ctrl_dec.sv
// Control bus decoder shared by the simple I/O peripherals.
// A bus cycle is valid only when the reserved upper control bits are zero.
module ctrl_dec
    import xsoc_io_pkg::*;
(
    input  logic        reset,
    input  logic [15:0] ctrl,
    input  logic        sel,
    output logic        ld_t,
    output logic        ld_ce,
    output logic        addr
);

    logic valid;

    assign valid = (ctrl[15:3] == 13'd0);
    assign ld_t  = reset | ~valid | ~ctrl[CTRL_RD];
    assign ld_ce = ~reset & sel & valid & ctrl[CTRL_WR];
    assign addr  = ctrl[CTRL_ADDR];

endmodule

// File: rtl/sync_fall.sv
// Multi-flop synchronizer for an asynchronous active-low strobe, plus a
// delay flop giving a single-cycle falling-edge pulse on the synchronized signal.
module sync_fall #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_n,
    output logic sync_out,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              dly;

    always_ff @(posedge clk) begin
        if (!rst) begin
            chain <= '1;
            dly   <= 1'b1;
        end else begin
            chain <= {chain[STAGES-2:0], async_n};
            dly   <= chain[STAGES-1];
        end
    end

    assign sync_out = chain[STAGES-1];
    assign fall     = ~sync_out & dly;

endmodule

// File: rtl/xin8_hs.sv
// Handshaked 8-bit input port: latches a strobed external byte, holds busy
// until the CPU reads it, then answers with a fixed-width ack_n pulse.
module xin8_hs
    import xsoc_io_pkg::*;
#(
    parameter int ACK_CYC     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ctrl,
    input  logic        sel,
    inout  wire  [7:0]  d,
    input  logic [7:0]  i,
    input  logic        stb_n,
    output logic        ack_n,
    output logic        busy
);

    localparam logic [3:0] ACK_LOAD = 4'(ACK_CYC - 1);

    logic       ld_t, ld_ce, addr;
    logic       rd, wr, data_rd, stat_rd, stat_wr, rd_clear;
    logic       stb_sync, stb_fall;
    logic [7:0] data_q, stat;
    logic       full, ovr, rd_prev;
    ack_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ack_n_d;

    ctrl_dec u_dec (
        .reset (~rst),
        .ctrl  (ctrl),
        .sel   (sel),
        .ld_t  (ld_t),
        .ld_ce (ld_ce),
        .addr  (addr)
    );

    sync_fall #(.STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_n  (stb_n),
        .sync_out (stb_sync),
        .fall     (stb_fall)
    );

    assign rd       = sel & ~ld_t;
    assign wr       = ld_ce;
    assign data_rd  = rd & (addr == REG_DATA);
    assign stat_rd  = rd & (addr == REG_STAT);
    assign stat_wr  = wr & (addr == REG_STAT);
    assign rd_clear = data_rd & ~rd_prev;

    // A read in the same cycle as a new strobe wins: the byte is dropped and
    // flagged as an overrun so the writer retries after the ack pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q  <= 8'h00;
            full    <= 1'b0;
            ovr     <= 1'b0;
            rd_prev <= 1'b0;
        end else begin
            rd_prev <= data_rd;
            if (rd_clear) begin
                full <= 1'b0;
            end else if (stb_fall && !full) begin
                full   <= 1'b1;
                data_q <= i;
            end
            if (stb_fall && (full || rd_clear)) begin
                ovr <= 1'b1;
            end else if (stat_wr && d[ST_OVR]) begin
                ovr <= 1'b0;
            end
        end
    end

    always_comb begin
        stat          = 8'h00;
        stat[ST_FULL] = full;
        stat[ST_OVR]  = ovr;
        stat[ST_STB]  = ~stb_sync;
    end

    assign d    = data_rd ? data_q : (stat_rd ? stat : 8'bz);
    assign busy = full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ack_n   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_n   <= ack_n_d;
        end
    end

    // A fresh read during the pulse reloads the counter, stretching ack_n.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_n_d = ack_n;
        case (state_q)
            IDLE: begin
                if (rd_clear) begin
                    state_d = ACK;
                    cnt_d   = ACK_LOAD;
                    ack_n_d = 1'b0;
                end
            end
            ACK: begin
                if (rd_clear) begin
                    cnt_d = ACK_LOAD;
                end else if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    ack_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                ack_n_d = 1'b1;
            end
        endcase
    end

endmodule
